// File: rtl/apb_master.sv
// apb_master: single-outstanding APB3 requester bridging a valid/ready command stream to APB
//
// Parameters
//   DW       data width of pwdata/prdata and command/response data
//   AW       address width of paddr and cmd_addr
//   TIMEOUT  pready-low cycles tolerated in ACCESS before abort; 0 disables the timeout
//
// Ports
//   pclk, presetn                       clock, asynchronous active-low reset
//   cmd_valid/cmd_ready                 command handshake (cmd_ready only in IDLE)
//   cmd_write, cmd_addr, cmd_wdata      command payload
//   rsp_valid/rsp_ready                 response handshake
//   rsp_rdata, rsp_err                  read data (0 for writes/aborts), error flag
//   psel, penable, pwrite, paddr, pwdata  registered APB request outputs
//   prdata, pready, pslverr             APB completer inputs
module apb_master #(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int TIMEOUT = 16
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          psel,
    output logic          penable,
    output logic          pwrite,
    output logic [AW-1:0] paddr,
    output logic [DW-1:0] pwdata,
    input  logic [DW-1:0] prdata,
    input  logic          pready,
    input  logic          pslverr
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t        r_state, w_state;
    logic          r_psel, w_psel;
    logic          r_penable, w_penable;
    logic          r_pwrite, w_pwrite;
    logic [AW-1:0] r_paddr, w_paddr;
    logic [DW-1:0] r_pwdata, w_pwdata;
    logic          r_rsp_valid, w_rsp_valid;
    logic [DW-1:0] r_rsp_rdata, w_rsp_rdata;
    logic          r_rsp_err, w_rsp_err;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [CW-1:0] w_cnt_inc;
    logic          w_timeout;

    // Saturating increment; the abort compares against the post-increment value so
    // penable is high for exactly TIMEOUT cycles before the bus is released.
    assign w_cnt_inc = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + CW'(1);
    assign w_timeout = (TIMEOUT != 0) && (w_cnt_inc == TO);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state     <= IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state;
            r_psel      <= w_psel;
            r_penable   <= w_penable;
            r_pwrite    <= w_pwrite;
            r_paddr     <= w_paddr;
            r_pwdata    <= w_pwdata;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_rdata <= w_rsp_rdata;
            r_rsp_err   <= w_rsp_err;
            r_cnt       <= w_cnt;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_psel      = r_psel;
        w_penable   = r_penable;
        w_pwrite    = r_pwrite;
        w_paddr     = r_paddr;
        w_pwdata    = r_pwdata;
        w_rsp_valid = r_rsp_valid;
        w_rsp_rdata = r_rsp_rdata;
        w_rsp_err   = r_rsp_err;
        w_cnt       = r_cnt;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_state   = SETUP;
                    w_psel    = 1'b1;
                    w_penable = 1'b0;
                    w_pwrite  = cmd_write;
                    w_paddr   = cmd_addr;
                    w_pwdata  = cmd_wdata;
                    w_cnt     = '0;
                end
            end
            SETUP: begin
                w_state   = ACCESS;
                w_penable = 1'b1;
            end
            ACCESS: begin
                if (pready) begin
                    w_state     = RESP;
                    w_psel      = 1'b0;
                    w_penable   = 1'b0;
                    w_rsp_valid = 1'b1;
                    w_rsp_rdata = r_pwrite ? '0 : prdata;
                    w_rsp_err   = pslverr;
                end else begin
                    w_cnt = w_cnt_inc;
                    if (w_timeout) begin
                        w_state     = RESP;
                        w_psel      = 1'b0;
                        w_penable   = 1'b0;
                        w_rsp_valid = 1'b1;
                        w_rsp_rdata = '0;
                        w_rsp_err   = 1'b1;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state     = IDLE;
                    w_rsp_valid = 1'b0;
                end
            end
            default: begin
                w_state     = IDLE;
                w_psel      = 1'b0;
                w_penable   = 1'b0;
                w_rsp_valid = 1'b0;
            end
        endcase
    end

    assign cmd_ready = (r_state == IDLE);
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule
